uart_out_arbiter: RTL and testbench
===================================

# uart_out_arbiter

Shares the single response channel of the UART I/O handler between two sources: the master's command responses and an interrupt notifier. It sits between the wishbone master core and the I/O handler's out_en / out_ready / out_status / out_address / out_data port. It grants the channel round-robin, coalesces interrupt edges into one pending vector, and tracks the handler's busy/idle handshake, with a timeout.

## Interface
- IRQ_STATUS, 32'h0000_0004: value driven on out_status for interrupt messages
- BUSY_TIMEOUT, 16: max cycles after out_en for out_ready to drop before abort (≥2)
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-low
- cmd_valid  in  1  command response pending
- cmd_ready  out  1  response accepted this cycle
- cmd_status / cmd_address / cmd_data  in  32 each  response payload
- irq_en  in  1  enable capture of new interrupt edges
- irq_vector  in  32  level interrupt lines
- out_en  out  1  one-cycle send strobe to I/O handler
- out_status / out_address / out_data  out  32 each  message to handler
- out_ready  in  1  handler idle (high) / sending (low)
- arb_busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle pulse on handshake timeout

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- Interrupt capture runs every cycle. It keeps irq_prev.
  - rise = irq_vector & ~irq_prev.
  - If irq_en, pend <= pend | rise.
  - irq_prev tracks irq_vector regardless of irq_en.
  - pend is retained when irq_en drops.
- irq_req = (pend != 0). last_grant is one bit (CMD/IRQ).
- Grant happens only in IDLE with out_ready=1:
  - cmd only requesting → cmd.
  - irq only requesting → irq.
  - both → the source opposite last_grant.
- cmd_ready = IDLE & out_ready & ~(irq_req & last_grant==CMD). It is independent of cmd_valid.
- cmd grant (cmd_valid & cmd_ready):
  - latch the cmd_* payload into out_*.
  - last_grant <= CMD; go to ISSUE.
- irq grant:
  - out_status <= IRQ_STATUS, out_address <= 0, out_data <= pend | rise (same-cycle edges included).
  - pend <= 0; last_grant <= IRQ; go to ISSUE.
- ISSUE: out_en=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: a counter increments each cycle.
  - out_ready=0 → WAIT_DONE.
  - If the counter reaches BUSY_TIMEOUT first → timeout_err pulse, go to IDLE. The message is lost and not retried.
- WAIT_DONE: out_ready=1 → IDLE.
- out_status/out_address/out_data hold from grant until the next grant.

## Timing
- Reset values: out_en=0, out_status/out_address/out_data=0, cmd_ready=0, arb_busy=0, timeout_err=0.
- Internal state at reset: pend=0, irq_prev=0, last_grant=IRQ (so cmd wins the first tie), counter=0, state IDLE.
- irq_prev resets to 0, so lines already high when reset releases register as edges on the first cycle.
- Reset mid-message drops the message; out_en is never reissued.
- Grant at cycle T. out_en and out_* are valid at T+1. The earliest next grant is the cycle after out_ready returns high.
- An edge arriving in the grant cycle goes into that message. An edge arriving in any later cycle goes into pend for the next message.
- The timeout counter clears on entry to WAIT_BUSY. out_ready=0 arriving on exactly count BUSY_TIMEOUT−1 is still accepted.
- cmd_valid dropping without cmd_ready: no effect.

## Structure
- Shared include uart_arb_defines.v holds:
  - state encodings (2-bit)
  - CMD/IRQ grant encodings
  - default IRQ_STATUS
- Sub-module irq_edge_collector:
  - inputs: clk, rst, irq_en, irq_vector, clr
  - outputs: pend, rise
  - performs the edge detect and OR-accumulate.
- FSM, arbitration and timeout live in the top.

## Test plan
- cmd only: cmd_valid=1 with status 1, addr 0x10, data 0xDEADBEEF. Handler drops out_ready at T+2 and raises it at T+12. Expect cmd_ready high one cycle at T, out_en at T+1 only, payload held, arb_busy low at T+13.
- Tie after reset: cmd pending and irq_vector bit 3 rising at the same time. Expect cmd sent first, then an irq message with out_status=4, out_address=0, out_data=0x8. A third tie goes to cmd.
- Coalescing: bits 0 and 5 rise while a cmd message is in flight. Expect one irq message with out_data=0x21 and pend cleared.
- irq_en=0: bit 2 rises → no message. irq_en set to 1 later with bit 2 still high → still no message, since it was not a new edge.
- Timeout: out_ready stays 1 after out_en. Expect timeout_err one cycle, BUSY_TIMEOUT cycles after entry to WAIT_BUSY, then return to IDLE and service the next request.
- Reset asserted in WAIT_DONE: expect all outputs zero next cycle and pend cleared. A line held high through reset produces an irq message after release.

Source files
------------

// File: rtl/uart_out_arbiter_pkg.sv
// Shared encodings and defaults for the UART response-channel arbiter.
package uart_out_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_CMD = 1'b0,
    GRANT_IRQ = 1'b1
  } grant_t;

  localparam logic [31:0] IRQ_STATUS_DEFAULT   = 32'h0000_0004;
  localparam int          BUSY_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/uart_out_arbiter_irq_edge_collector.sv
// Rising-edge detector on the interrupt lines that OR-accumulates enabled
// edges into a pending vector until the arbiter sends them.
module irq_edge_collector (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_en,
  input  logic [31:0] irq_vector,
  input  logic        clr,
  output logic [31:0] pend,
  output logic [31:0] rise
);

  logic [31:0] irq_prev;

  assign rise = irq_vector & ~irq_prev;

  // clr wins over same-cycle edges because the arbiter folds those into the message it sends
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_prev <= '0;
      pend     <= '0;
    end else begin
      irq_prev <= irq_vector;
      if (clr) begin
        pend <= '0;
      end else if (irq_en) begin
        pend <= pend | rise;
      end
    end
  end

endmodule

// File: rtl/uart_out_arbiter.sv
// Round-robin arbiter sharing the UART I/O handler response channel between
// command responses and coalesced interrupt notifications, with busy timeout.
module uart_out_arbiter
  import uart_out_arbiter_pkg::*;
#(
  parameter logic [31:0] IRQ_STATUS   = IRQ_STATUS_DEFAULT,
  parameter int          BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_status,
  input  logic [31:0] cmd_address,
  input  logic [31:0] cmd_data,
  input  logic        irq_en,
  input  logic [31:0] irq_vector,
  output logic        out_en,
  output logic [31:0] out_status,
  output logic [31:0] out_address,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        arb_busy,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t       state;
  arb_state_t       next_state;
  grant_t           last_grant;
  logic [CNT_W-1:0] count;
  logic [31:0]      pend;
  logic [31:0]      rise;
  logic [31:0]      irq_msg;
  logic             irq_req;
  logic             cmd_grant;
  logic             irq_grant;
  logic             timeout_hit;

  irq_edge_collector u_irq (
    .clk        (clk),
    .rst        (rst),
    .irq_en     (irq_en),
    .irq_vector (irq_vector),
    .clr        (irq_grant),
    .pend       (pend),
    .rise       (rise)
  );

  assign irq_req  = |pend;
  assign irq_msg  = pend | (irq_en ? rise : 32'h0);
  assign out_en   = (state == ST_ISSUE);
  assign arb_busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // cmd_ready is withheld only when the interrupt side is owed its turn
  always_comb begin
    next_state  = state;
    cmd_ready   = 1'b0;
    cmd_grant   = 1'b0;
    irq_grant   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rst && out_ready) begin
          cmd_ready = !(irq_req && (last_grant == GRANT_CMD));
          cmd_grant = cmd_valid && cmd_ready;
          irq_grant = irq_req && !cmd_grant;
          if (cmd_grant || irq_grant) next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!out_ready) begin
          next_state = ST_WAIT_DONE;
        end else if (count == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          next_state  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant  <= GRANT_IRQ;
      count       <= '0;
      timeout_err <= 1'b0;
      out_status  <= '0;
      out_address <= '0;
      out_data    <= '0;
    end else begin
      timeout_err <= timeout_hit;
      if (state == ST_ISSUE) begin
        count <= '0;
      end else if (state == ST_WAIT_BUSY) begin
        count <= count + 1'b1;
      end
      if (cmd_grant) begin
        out_status  <= cmd_status;
        out_address <= cmd_address;
        out_data    <= cmd_data;
        last_grant  <= GRANT_CMD;
      end else if (irq_grant) begin
        out_status  <= IRQ_STATUS;
        out_address <= '0;
        out_data    <= irq_msg;
        last_grant  <= GRANT_IRQ;
      end
    end
  end

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Directed self-checking bench for uart_out_arbiter: one task per scenario,
// expected values computed by hand from the intended cycle behaviour.
module tb_uart_out_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_status;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;
  logic        irq_en;
  logic [31:0] irq_vector;
  logic        out_en;
  logic [31:0] out_status;
  logic [31:0] out_address;
  logic [31:0] out_data;
  logic        out_ready;
  logic        arb_busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_out_arbiter #(
    .IRQ_STATUS   (32'h0000_0004),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_status  (cmd_status),
    .cmd_address (cmd_address),
    .cmd_data    (cmd_data),
    .irq_en      (irq_en),
    .irq_vector  (irq_vector),
    .out_en      (out_en),
    .out_status  (out_status),
    .out_address (out_address),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] s, input logic [31:0] a, input logic [31:0] d);
    cmd_valid   = 1'b1;
    cmd_status  = s;
    cmd_address = a;
    cmd_data    = d;
  endtask

  // Called in the ISSUE cycle; returns in the first IDLE cycle afterwards
  task automatic handshake(input int busy_cycles);
    tick();
    out_ready = 1'b0;
    tick();
    repeat (busy_cycles) tick();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    cmd_valid  = 1'b0;
    irq_vector = 32'h0;
    irq_en     = 1'b1;
    out_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    cmd_valid   = 1'b0;
    cmd_status  = 32'h0;
    cmd_address = 32'h0;
    cmd_data    = 32'h0;
    irq_en      = 1'b1;
    irq_vector  = 32'h0;
    out_ready   = 1'b1;
    repeat (3) tick();
    checks++; if (out_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_en got %b exp 0", out_en); end
    checks++; if (out_status !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_status got %h exp 0", out_status); end
    checks++; if (out_address !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_address got %h exp 0", out_address); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_arb_busy got %b exp 0", arb_busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err got %b exp 0", timeout_err); end
    rst = 1'b1;
    #1;
  endtask

  task automatic test_cmd_only();
    set_cmd(32'h1, 32'h10, 32'hDEAD_BEEF);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL cmd_ready_T got %b exp 1", cmd_ready); end
    checks++; if (out_en !== 1'b0) begin errors++; $display("[TB] FAIL cmd_out_en_T got %b exp 0", out_en); end
    tick();
    cmd_valid = 1'b0;
    #1;
    checks++; if (out_en !== 1'b1) begin errors++; $display("[TB] FAIL cmd_out_en_T1 got %b exp 1", out_en); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL cmd_ready_T1 got %b exp 0", cmd_ready); end
    checks++; if (out_status !== 32'h1) begin errors++; $display("[TB] FAIL cmd_out_status got %h exp 1", out_status); end
    checks++; if (out_address !== 32'h10) begin errors++; $display("[TB] FAIL cmd_out_address got %h exp 10", out_address); end
    checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL cmd_out_data got %h exp deadbeef", out_data); end
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("[TB] FAIL cmd_busy_T1 got %b exp 1", arb_busy); end
    tick();
    checks++; if (out_en !== 1'b0) begin errors++; $display("[TB] FAIL cmd_out_en_T2 got %b exp 0", out_en); end
    out_ready = 1'b0;
    repeat (10) tick();
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("[TB] FAIL cmd_busy_T12 got %b exp 1", arb_busy); end
    checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL cmd_hold_T12 got %h exp deadbeef", out_data); end
    checks++; if (out_en !== 1'b0) begin errors++; $display("[TB] FAIL cmd_out_en_T12 got %b exp 0", out_en); end
    out_ready = 1'b1;
    tick();
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL cmd_busy_T13 got %b exp 0", arb_busy); end
  endtask

  task automatic test_tie();
    do_reset();
    irq_vector = 32'h8;
    tick();
    set_cmd(32'h2, 32'h20, 32'h1111);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL tie1_cmd_ready got %b exp 1", cmd_ready); end
    tick();
    checks++; if (out_data !== 32'h1111) begin errors++; $display("[TB] FAIL tie1_out_data got %h exp 1111", out_data); end
    set_cmd(32'h3, 32'h30, 32'h2222);
    handshake(1);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL tie2_cmd_ready got %b exp 0", cmd_ready); end
    tick();
    checks++; if (out_en !== 1'b1) begin errors++; $display("[TB] FAIL tie2_out_en got %b exp 1", out_en); end
    checks++; if (out_status !== 32'h4) begin errors++; $display("[TB] FAIL tie2_out_status got %h exp 4", out_status); end
    checks++; if (out_address !== 32'h0) begin errors++; $display("[TB] FAIL tie2_out_address got %h exp 0", out_address); end
    checks++; if (out_data !== 32'h8) begin errors++; $display("[TB] FAIL tie2_out_data got %h exp 8", out_data); end
    irq_vector = 32'hA;
    handshake(1);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL tie3_cmd_ready got %b exp 1", cmd_ready); end
    tick();
    checks++; if (out_data !== 32'h2222) begin errors++; $display("[TB] FAIL tie3_out_data got %h exp 2222", out_data); end
    checks++; if (out_status !== 32'h3) begin errors++; $display("[TB] FAIL tie3_out_status got %h exp 3", out_status); end
    cmd_valid = 1'b0;
    handshake(1);
  endtask

  task automatic test_coalesce();
    do_reset();
    set_cmd(32'h5, 32'h50, 32'h5555);
    tick();
    cmd_valid  = 1'b0;
    irq_vector = 32'h1;
    tick();
    irq_vector = 32'h21;
    out_ready  = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL coal_cmd_ready got %b exp 0", cmd_ready); end
    tick();
    checks++; if (out_en !== 1'b1) begin errors++; $display("[TB] FAIL coal_out_en got %b exp 1", out_en); end
    checks++; if (out_status !== 32'h4) begin errors++; $display("[TB] FAIL coal_out_status got %h exp 4", out_status); end
    checks++; if (out_address !== 32'h0) begin errors++; $display("[TB] FAIL coal_out_address got %h exp 0", out_address); end
    checks++; if (out_data !== 32'h21) begin errors++; $display("[TB] FAIL coal_out_data got %h exp 21", out_data); end
    handshake(1);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL coal_pend_clear got %b exp 1", cmd_ready); end
    tick();
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL coal_no_second got %b exp 0", arb_busy); end
  endtask

  task automatic test_irq_en();
    irq_en     = 1'b0;
    irq_vector = 32'h25;
    repeat (4) tick();
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL irqen_off_busy got %b exp 0", arb_busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL irqen_off_ready got %b exp 1", cmd_ready); end
    irq_en = 1'b1;
    repeat (3) tick();
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL irqen_on_busy got %b exp 0", arb_busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL irqen_on_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_timeout();
    set_cmd(32'h6, 32'h60, 32'h6666);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_early_%0d got %b exp 0", k, timeout_err); end
      tick();
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_pulse got %b exp 1", timeout_err); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL tmo_idle got %b exp 0", arb_busy); end
    set_cmd(32'h7, 32'h70, 32'h7777);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL tmo_next_ready got %b exp 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_one_cycle got %b exp 0", timeout_err); end
    checks++; if (out_en !== 1'b1) begin errors++; $display("[TB] FAIL tmo_next_out_en got %b exp 1", out_en); end
    checks++; if (out_data !== 32'h7777) begin errors++; $display("[TB] FAIL tmo_next_data got %h exp 7777", out_data); end
    tick();
    repeat (15) tick();
    out_ready = 1'b0;
    tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_edge_err got %b exp 0", timeout_err); end
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("[TB] FAIL tmo_edge_busy got %b exp 1", arb_busy); end
    out_ready = 1'b1;
    tick();
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL tmo_edge_done got %b exp 0", arb_busy); end
  endtask

  task automatic test_reset_midmsg();
    set_cmd(32'h8, 32'h80, 32'h8888);
    tick();
    cmd_valid = 1'b0;
    tick();
    out_ready  = 1'b0;
    irq_vector = 32'h125;
    tick();
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy got %b exp 1", arb_busy); end
    rst        = 1'b0;
    out_ready  = 1'b1;
    irq_vector = 32'h1;
    tick();
    checks++; if (out_en !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out_en got %b exp 0", out_en); end
    checks++; if (out_status !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_status got %h exp 0", out_status); end
    checks++; if (out_address !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_address got %h exp 0", out_address); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_data got %h exp 0", out_data); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_arb_busy got %b exp 0", arb_busy); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_cmd_ready got %b exp 0", cmd_ready); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstrel_busy got %b exp 0", arb_busy); end
    tick();
    tick();
    checks++; if (out_en !== 1'b1) begin errors++; $display("[TB] FAIL rstrel_out_en got %b exp 1", out_en); end
    checks++; if (out_status !== 32'h4) begin errors++; $display("[TB] FAIL rstrel_status got %h exp 4", out_status); end
    checks++; if (out_address !== 32'h0) begin errors++; $display("[TB] FAIL rstrel_address got %h exp 0", out_address); end
    checks++; if (out_data !== 32'h1) begin errors++; $display("[TB] FAIL rstrel_data got %h exp 1", out_data); end
    handshake(1);
  endtask

  initial begin
    test_reset();
    test_cmd_only();
    test_tie();
    test_coalesce();
    test_irq_en();
    test_timeout();
    test_reset_midmsg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
